multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit_if.sv | 61 ++++++
 rtl/multicycle_control_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control unit <-> datapath signal bundle
//
// Purpose : groups the instruction/flag inputs and all datapath control
//           outputs of multicycle_control_unit into one interface.
// Modports: master - the control unit (drives the control selects/enables)
//           slave  - the datapath / bench side (drives Run, instruction fields, flags)
// Option  : CU_INSTR_COUNT_EN adds the 16-bit Instr_Count output.
interface multicycle_control_unit_if;
  logic       Run;
  logic       Ext_Wr_en;
  logic [4:0] Opcode;
  logic [1:0] ALU_Op;
  logic [2:0] Rd_Addr;
  logic       Z_Reg;
  logic       C_Reg;

  logic       PC_CE;
  logic       PC_Add_Src;
  logic       PC_ALU_Sel;
  logic [1:0] PC_Sel;
  logic       Mem_Addr_Sel;
  logic       MemW_Data_Sel;
  logic       MemW_en;
  logic       Rd_Reg_CE;
  logic       Rd_Rm_Sel;
  logic       ALUOut_Reg_CE;
  logic       Z_CE;
  logic       C_CE;
  logic       RF_Write_en;
  logic       Out_R_CE;
  logic [1:0] Imm_Sel;
  logic [1:0] ALU_B_Sel;
  logic [1:0] ALU_Control;
  logic [1:0] RF_Write_Data_Sel;
  logic       Halted;
`ifdef CU_INSTR_COUNT_EN
  logic [15:0] Instr_Count;
`endif

  modport master (
    input  Run, Ext_Wr_en, Opcode, ALU_Op, Rd_Addr, Z_Reg, C_Reg,
`ifdef CU_INSTR_COUNT_EN
    output Instr_Count,
`endif
    output PC_CE, PC_Add_Src, PC_ALU_Sel, PC_Sel,
    output Mem_Addr_Sel, MemW_Data_Sel, MemW_en,
    output Rd_Reg_CE, Rd_Rm_Sel, ALUOut_Reg_CE, Z_CE, C_CE, RF_Write_en, Out_R_CE,
    output Imm_Sel, ALU_B_Sel, ALU_Control, RF_Write_Data_Sel, Halted
  );

  modport slave (
    output Run, Ext_Wr_en, Opcode, ALU_Op, Rd_Addr, Z_Reg, C_Reg,
`ifdef CU_INSTR_COUNT_EN
    input  Instr_Count,
`endif
    input  PC_CE, PC_Add_Src, PC_ALU_Sel, PC_Sel,
    input  Mem_Addr_Sel, MemW_Data_Sel, MemW_en,
    input  Rd_Reg_CE, Rd_Rm_Sel, ALUOut_Reg_CE, Z_CE, C_CE, RF_Write_en, Out_R_CE,
    input  Imm_Sel, ALU_B_Sel, ALU_Control, RF_Write_Data_Sel, Halted
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore FSM sequencing a multicycle CPU datapath
//
// Purpose : IDLE -> PCRST -> FETCH -> DECODE -> EXEC -> (WB | MEM) -> FETCH,
//           with HALT left only by reset. Instruction fields are latched at
//           the end of DECODE and EXEC decodes the latched copy only.
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset; forces IDLE and all outputs low
//           cu_bus - multicycle_control_unit_if.master (inputs + control outputs)
// Option  : define CU_INSTR_COUNT_EN for the Instr_Count retired-instruction counter.
module multicycle_control_unit (
  input  logic                         clk,
  input  logic                         rst_n,
  multicycle_control_unit_if.master    cu_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PCRST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [4:0] r_opcode;
  logic [1:0] r_alu_op;
  logic [2:0] r_rd_addr;
  logic       w_cond_true;
  logic       w_is_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_opcode  <= '0;
      r_alu_op  <= '0;
      r_rd_addr <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_opcode  <= cu_bus.Opcode;
        r_alu_op  <= cu_bus.ALU_Op;
        r_rd_addr <= cu_bus.Rd_Addr;
      end
    end
  end

  // Conditional branch predicate; codes 100-111 never take the branch.
  always_comb begin
    w_cond_true = 1'b0;
    case (r_rd_addr)
      3'b000:  w_cond_true = cu_bus.Z_Reg;
      3'b001:  w_cond_true = ~cu_bus.Z_Reg;
      3'b010:  w_cond_true = cu_bus.C_Reg;
      3'b011:  w_cond_true = ~cu_bus.C_Reg;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Only 00101 and 00110/00 reach MEM as stores; the other MEM entries are loads.
  assign w_is_store = (r_opcode == 5'b00101) || (r_opcode == 5'b00110);

  always_comb begin
    w_next_state                = r_state;
    cu_bus.PC_CE                = 1'b0;
    cu_bus.PC_Add_Src           = 1'b0;
    cu_bus.PC_ALU_Sel           = 1'b0;
    cu_bus.PC_Sel               = 2'b00;
    cu_bus.Mem_Addr_Sel         = 1'b0;
    cu_bus.MemW_Data_Sel        = 1'b0;
    cu_bus.MemW_en              = 1'b0;
    cu_bus.Rd_Reg_CE            = 1'b0;
    cu_bus.Rd_Rm_Sel            = 1'b0;
    cu_bus.ALUOut_Reg_CE        = 1'b0;
    cu_bus.Z_CE                 = 1'b0;
    cu_bus.C_CE                 = 1'b0;
    cu_bus.RF_Write_en          = 1'b0;
    cu_bus.Out_R_CE             = 1'b0;
    cu_bus.Imm_Sel              = 2'b00;
    cu_bus.ALU_B_Sel            = 2'b00;
    cu_bus.ALU_Control          = 2'b00;
    cu_bus.RF_Write_Data_Sel    = 2'b00;
    cu_bus.Halted               = 1'b0;
    // Gating on rst_n keeps every output low for as long as reset is held,
    // including the IDLE memory-load selects and Ext_Wr_en pass-through.
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          cu_bus.Mem_Addr_Sel  = 1'b1;
          cu_bus.MemW_Data_Sel = 1'b1;
          cu_bus.MemW_en       = cu_bus.Ext_Wr_en;
          if (cu_bus.Run) w_next_state = S_PCRST;
        end
        S_PCRST: begin
          cu_bus.PC_Sel = 2'b11;
          cu_bus.PC_CE  = 1'b1;
          w_next_state  = S_FETCH;
        end
        S_FETCH: w_next_state = S_DECODE;
        S_DECODE: begin
          cu_bus.PC_CE     = 1'b1;
          cu_bus.Rd_Reg_CE = 1'b1;
          w_next_state     = S_EXEC;
        end
        S_EXEC: begin
          w_next_state = S_FETCH;
          case (r_opcode)
            5'b00000, 5'b00111, 5'b01000: begin
              cu_bus.Rd_Rm_Sel     = 1'b1;
              cu_bus.ALUOut_Reg_CE = 1'b1;
              cu_bus.Z_CE          = 1'b1;
              cu_bus.C_CE          = 1'b1;
              if (r_opcode == 5'b00000) begin
                cu_bus.ALU_Control = r_alu_op;
              end else begin
                cu_bus.ALU_B_Sel   = 2'b01;
                cu_bus.ALU_Control = (r_opcode == 5'b01000) ? 2'b10 : 2'b00;
              end
              w_next_state = S_WB;
            end
            5'b00001, 5'b00010: begin
              cu_bus.Imm_Sel           = (r_opcode == 5'b00001) ? 2'b11 : 2'b10;
              cu_bus.RF_Write_Data_Sel = 2'b01;
              cu_bus.RF_Write_en       = 1'b1;
            end
            5'b00011, 5'b00100, 5'b00101: begin
              cu_bus.Rd_Rm_Sel     = 1'b1;
              cu_bus.ALU_B_Sel     = (r_opcode == 5'b00100) ? 2'b00 : 2'b01;
              cu_bus.ALUOut_Reg_CE = 1'b1;
              w_next_state         = S_MEM;
            end
            5'b00110: begin
              if (r_alu_op == 2'b01) begin
                cu_bus.Rd_Rm_Sel     = 1'b1;
                cu_bus.ALUOut_Reg_CE = 1'b1;
                cu_bus.Z_CE          = 1'b1;
                cu_bus.C_CE          = 1'b1;
                cu_bus.ALU_Control   = 2'b10;
              end else if (r_alu_op == 2'b00) begin
                cu_bus.Rd_Rm_Sel     = 1'b1;
                cu_bus.ALUOut_Reg_CE = 1'b1;
                w_next_state         = S_MEM;
              end
            end
            5'b01011: begin
              cu_bus.Rd_Rm_Sel     = 1'b1;
              cu_bus.ALU_B_Sel     = 2'b10;
              cu_bus.ALUOut_Reg_CE = 1'b1;
              w_next_state         = S_WB;
            end
            5'b10000: begin
              cu_bus.PC_Sel = 2'b01;
              cu_bus.PC_CE  = 1'b1;
            end
            5'b10001: begin
              // PC still holds PC+1 here, so Rd gets the return address while PC moves.
              cu_bus.RF_Write_Data_Sel = 2'b11;
              cu_bus.RF_Write_en       = 1'b1;
              cu_bus.PC_Add_Src        = 1'b1;
              cu_bus.Imm_Sel           = 2'b01;
              cu_bus.PC_CE             = 1'b1;
            end
            5'b10010: begin
              cu_bus.RF_Write_Data_Sel = 2'b11;
              cu_bus.RF_Write_en       = 1'b1;
              cu_bus.Rd_Rm_Sel         = 1'b1;
              cu_bus.PC_Sel            = 2'b10;
              cu_bus.PC_CE             = 1'b1;
            end
            5'b10011: begin
              cu_bus.PC_Sel = 2'b10;
              cu_bus.PC_CE  = 1'b1;
            end
            5'b11000, 5'b11001: begin
              if (r_opcode == 5'b11001 || w_cond_true) begin
                cu_bus.PC_Add_Src = 1'b1;
                cu_bus.Imm_Sel    = 2'b01;
                cu_bus.PC_CE      = 1'b1;
              end
            end
            5'b11100: begin
              if (r_alu_op == 2'b00) begin
                cu_bus.Rd_Rm_Sel = 1'b1;
                cu_bus.Out_R_CE  = 1'b1;
              end else if (r_alu_op == 2'b01) begin
                w_next_state = S_HALT;
              end
            end
            default: ;
          endcase
        end
        S_MEM: begin
          cu_bus.PC_ALU_Sel = 1'b1;
          if (w_is_store) begin
            cu_bus.MemW_en = 1'b1;
          end else begin
            cu_bus.RF_Write_en = 1'b1;
          end
          w_next_state = S_FETCH;
        end
        S_WB: begin
          cu_bus.RF_Write_Data_Sel = 2'b10;
          cu_bus.RF_Write_en       = 1'b1;
          w_next_state             = S_FETCH;
        end
        S_HALT: cu_bus.Halted = 1'b1;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

`ifdef CU_INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_count <= '0;
    end else if (w_next_state == S_FETCH &&
                 (r_state == S_EXEC || r_state == S_WB || r_state == S_MEM)) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign cu_bus.Instr_Count = r_instr_count;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic clk;
  logic rst_n;
  multicycle_control_unit_if cu_bus ();

  multicycle_control_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cu_bus (cu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_ce;
    logic       pc_add_src;
    logic       pc_alu_sel;
    logic [1:0] pc_sel;
    logic       mem_addr_sel;
    logic       memw_data_sel;
    logic       memw_en;
    logic       rd_reg_ce;
    logic       rd_rm_sel;
    logic       aluout_ce;
    logic       z_ce;
    logic       c_ce;
    logic       rf_we;
    logic       outr_ce;
    logic [1:0] imm_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_ctl;
    logic [1:0] rf_wd_sel;
    logic       halted;
  } ctl_t;

  localparam int NXT_FETCH = 0;
  localparam int NXT_WB    = 1;
  localparam int NXT_LOAD  = 2;
  localparam int NXT_STORE = 3;
  localparam int NXT_HALT  = 4;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  function automatic ctl_t sample();
    ctl_t s;
    s.pc_ce         = cu_bus.PC_CE;
    s.pc_add_src    = cu_bus.PC_Add_Src;
    s.pc_alu_sel    = cu_bus.PC_ALU_Sel;
    s.pc_sel        = cu_bus.PC_Sel;
    s.mem_addr_sel  = cu_bus.Mem_Addr_Sel;
    s.memw_data_sel = cu_bus.MemW_Data_Sel;
    s.memw_en       = cu_bus.MemW_en;
    s.rd_reg_ce     = cu_bus.Rd_Reg_CE;
    s.rd_rm_sel     = cu_bus.Rd_Rm_Sel;
    s.aluout_ce     = cu_bus.ALUOut_Reg_CE;
    s.z_ce          = cu_bus.Z_CE;
    s.c_ce          = cu_bus.C_CE;
    s.rf_we         = cu_bus.RF_Write_en;
    s.outr_ce       = cu_bus.Out_R_CE;
    s.imm_sel       = cu_bus.Imm_Sel;
    s.alu_b_sel     = cu_bus.ALU_B_Sel;
    s.alu_ctl       = cu_bus.ALU_Control;
    s.rf_wd_sel     = cu_bus.RF_Write_Data_Sel;
    s.halted        = cu_bus.Halted;
    return s;
  endfunction

  // Reference: what the instruction set says each instruction must do in EXEC
  // and which phase follows.
  function automatic ctl_t model_exec(input logic [4:0] op, input logic [1:0] aop,
                                      input logic [2:0] rd, input logic z, input logic c,
                                      output int nxt);
    ctl_t e;
    logic [3:0] cond_tbl;
    bit taken;
    e = '0;
    nxt = NXT_FETCH;
    cond_tbl = {~c, c, ~z, z};
    if (op == 0 || op == 7 || op == 8 || (op == 6 && aop == 1)) begin
      e.rd_rm_sel = 1; e.aluout_ce = 1; e.z_ce = 1; e.c_ce = 1;
      if (op == 0)      begin e.alu_ctl = aop; nxt = NXT_WB; end
      else if (op == 6) begin e.alu_ctl = 2'b10; end
      else              begin e.alu_b_sel = 2'b01; e.alu_ctl = (op == 8) ? 2'b10 : 2'b00; nxt = NXT_WB; end
    end else if (op == 11) begin
      e.rd_rm_sel = 1; e.alu_b_sel = 2'b10; e.aluout_ce = 1; nxt = NXT_WB;
    end else if (op == 1 || op == 2) begin
      e.imm_sel = (op == 1) ? 2'b11 : 2'b10; e.rf_wd_sel = 2'b01; e.rf_we = 1;
    end else if (op == 3 || op == 4 || op == 5 || (op == 6 && aop == 0)) begin
      e.rd_rm_sel = 1; e.aluout_ce = 1;
      e.alu_b_sel = (op == 3 || op == 5) ? 2'b01 : 2'b00;
      nxt = (op == 3 || op == 4) ? NXT_LOAD : NXT_STORE;
    end else if (op == 24 || op == 25) begin
      taken = (op == 25) || (rd < 4 && cond_tbl[rd[1:0]]);
      if (taken) begin e.pc_add_src = 1; e.imm_sel = 2'b01; e.pc_ce = 1; end
    end else if (op == 16) begin
      e.pc_sel = 2'b01; e.pc_ce = 1;
    end else if (op == 17) begin
      e.rf_wd_sel = 2'b11; e.rf_we = 1; e.pc_add_src = 1; e.imm_sel = 2'b01; e.pc_ce = 1;
    end else if (op == 18) begin
      e.rf_wd_sel = 2'b11; e.rf_we = 1; e.rd_rm_sel = 1; e.pc_sel = 2'b10; e.pc_ce = 1;
    end else if (op == 19) begin
      e.pc_sel = 2'b10; e.pc_ce = 1;
    end else if (op == 28 && aop == 0) begin
      e.rd_rm_sel = 1; e.outr_ce = 1;
    end else if (op == 28 && aop == 1) begin
      nxt = NXT_HALT;
    end
    return e;
  endfunction

  // IDLE -> PCRST -> FETCH; returns just after the edge entering FETCH.
  task automatic start_cpu();
    ctl_t exp, got;
    cu_bus.Run = 1'b1;
    @(posedge clk); #1;
    got = sample(); exp = '0; exp.pc_sel = 2'b11; exp.pc_ce = 1;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL pcrst got=%h exp=%h", got, exp); end
    cu_bus.Run = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs one instruction starting in FETCH; ends in FETCH (or HALT).
  task automatic run_instr(input logic [4:0] op, input logic [1:0] aop, input logic [2:0] rd,
                           input logic z, input logic c, input string tag);
    ctl_t exp, got;
    int nxt;
    cu_bus.Opcode = op; cu_bus.ALU_Op = aop; cu_bus.Rd_Addr = rd;
    cu_bus.Z_Reg = $urandom; cu_bus.C_Reg = $urandom;
    #1;
    got = sample(); exp = '0;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL %s fetch got=%h exp=%h", tag, got, exp); end
    @(posedge clk); #1;
    got = sample(); exp = '0; exp.pc_ce = 1; exp.rd_reg_ce = 1;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL %s decode got=%h exp=%h", tag, got, exp); end
    @(posedge clk); #1;
    // Scramble the live fields: EXEC must decode the copy latched in DECODE.
    cu_bus.Opcode = 5'($urandom); cu_bus.ALU_Op = 2'($urandom); cu_bus.Rd_Addr = 3'($urandom);
    cu_bus.Z_Reg = z; cu_bus.C_Reg = c;
    #1;
    got = sample(); exp = model_exec(op, aop, rd, z, c, nxt);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s exec op=%b aop=%b rd=%b z=%b c=%b got=%h exp=%h", tag, op, aop, rd, z, c, got, exp);
    end
    if (nxt != NXT_FETCH) begin
      @(posedge clk); #1;
      got = sample(); exp = '0;
      case (nxt)
        NXT_WB:    begin exp.rf_wd_sel = 2'b10; exp.rf_we = 1; end
        NXT_LOAD:  begin exp.pc_alu_sel = 1; exp.rf_wd_sel = 2'b00; exp.rf_we = 1; end
        NXT_STORE: begin exp.pc_alu_sel = 1; exp.memw_en = 1; end
        default:   exp.halted = 1;
      endcase
      checks++;
      if (got !== exp) begin failures++; $display("FAIL %s phase2 got=%h exp=%h", tag, got, exp); end
    end
    if (nxt != NXT_HALT) begin
      exp_count++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    ctl_t exp, got;
    rst_n = 1'b0; cu_bus.Run = 1'b0; cu_bus.Ext_Wr_en = 1'b1;
    cu_bus.Opcode = '0; cu_bus.ALU_Op = '0; cu_bus.Rd_Addr = '0;
    cu_bus.Z_Reg = 1'b0; cu_bus.C_Reg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = sample(); exp = '0;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_hold got=%h exp=%h", got, exp); end
    rst_n = 1'b1; #1;
    got = sample(); exp = '0; exp.mem_addr_sel = 1; exp.memw_data_sel = 1; exp.memw_en = 1;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL idle_ext_wr got=%h exp=%h", got, exp); end
    cu_bus.Ext_Wr_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    got = sample(); exp.memw_en = 0;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL idle_no_run got=%h exp=%h", got, exp); end
`ifdef CU_INSTR_COUNT_EN
    checks++;
    if (cu_bus.Instr_Count !== 16'd0) begin
      failures++; $display("FAIL count_reset got=%h exp=0000", cu_bus.Instr_Count);
    end
`endif
    exp_count = 0;
  endtask

  task automatic test_alu();
    for (int a = 0; a < 4; a++) run_instr(5'b00000, 2'(a), 3'($urandom), 1'($urandom), 1'($urandom), "alu");
    run_instr(5'b00110, 2'b01, 3'd2, 1'b0, 1'b1, "cmp");
    run_instr(5'b00111, 2'b00, 3'd1, 1'b0, 1'b0, "addi");
    run_instr(5'b01000, 2'b10, 3'd5, 1'b1, 1'b0, "subi");
  endtask

  task automatic test_ldr_str();
    run_instr(5'b00011, 2'b00, 3'd3, 1'b0, 1'b0, "ldr");
    run_instr(5'b00101, 2'b00, 3'd4, 1'b0, 1'b0, "str");
    run_instr(5'b00100, 2'b11, 3'd6, 1'b0, 1'b0, "ldr_reg");
    run_instr(5'b00110, 2'b00, 3'd7, 1'b0, 1'b0, "str_reg");
  endtask

  task automatic test_branch();
    run_instr(5'b11000, 2'b00, 3'b011, 1'b0, 1'b0, "bnc_taken");
    run_instr(5'b11000, 2'b00, 3'b011, 1'b0, 1'b1, "bnc_not");
    run_instr(5'b11000, 2'b00, 3'b000, 1'b1, 1'b0, "bz_taken");
    run_instr(5'b11000, 2'b00, 3'b110, 1'b1, 1'b1, "bcond_rsvd");
    run_instr(5'b11001, 2'b00, 3'b111, 1'b0, 1'b0, "bal");
  endtask

  task automatic test_random();
    logic [4:0] ops [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 11, 16, 17, 18, 19, 24, 25, 28};
    logic [4:0] op;
    logic [1:0] aop;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) op = ops[$urandom_range(0, 16)];
      else                           op = 5'($urandom);
      aop = 2'($urandom);
      if (op == 5'b11100 && aop == 2'b01) aop = 2'b00;
      run_instr(op, aop, 3'($urandom), 1'($urandom), 1'($urandom), "rand");
    end
`ifdef CU_INSTR_COUNT_EN
    checks++;
    if (cu_bus.Instr_Count !== 16'(exp_count)) begin
      failures++; $display("FAIL instr_count got=%0d exp=%0d", cu_bus.Instr_Count, exp_count);
    end
`endif
  endtask

  task automatic test_halt();
    ctl_t exp, got;
    run_instr(5'b11100, 2'b01, 3'd0, 1'b0, 1'b0, "hlt");
    cu_bus.Run = 1'b1;
    exp = '0; exp.halted = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      got = sample();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL halt_hold cyc=%0d got=%h exp=%h", i, got, exp); end
    end
    cu_bus.Run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    got = sample(); exp = '0;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL halt_async_rst got=%h exp=%h", got, exp); end
    #1 rst_n = 1'b1;
    #1;
    got = sample(); exp = '0; exp.mem_addr_sel = 1; exp.memw_data_sel = 1;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL halt_to_idle got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid_str();
    ctl_t exp, got;
    @(posedge clk); #1;
    start_cpu();
    cu_bus.Opcode = 5'b00101; cu_bus.ALU_Op = 2'b00; cu_bus.Rd_Addr = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cu_bus.MemW_en !== 1'b1) begin failures++; $display("FAIL str_mem_we got=%b exp=1", cu_bus.MemW_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cu_bus.MemW_en !== 1'b0) begin failures++; $display("FAIL str_async_we got=%b exp=0", cu_bus.MemW_en); end
    got = sample(); exp = '0;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL str_async_all got=%h exp=%h", got, exp); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    got = sample(); exp = '0; exp.mem_addr_sel = 1; exp.memw_data_sel = 1;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL str_rst_idle got=%h exp=%h", got, exp); end
  endtask

  initial begin
    test_reset();
    start_cpu();
    test_alu();
    test_ldr_str();
    test_branch();
    test_random();
    test_halt();
    test_reset_mid_str();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
